// File: rtl/board_mem_writer.sv
// Queues board-position updates and writes them into the display region of BRAM.
// A bulk clear fills the whole region once every update queued before it has been written.
module board_mem_writer #(
   parameter int unsigned           WIDTH      = 16,
   parameter int unsigned           ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h100,
   parameter int unsigned           NUM_POS    = 30,
   parameter int unsigned           FIFO_DEPTH = 4
) (
   input  logic                  clk50MHz,
   input  logic                  clr,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [4:0]            req_index,
   input  logic [WIDTH-1:0]      req_data,
   input  logic                  clear_start,
   input  logic [WIDTH-1:0]      clear_value,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   output logic                  mem_we,
   output logic                  busy,
   output logic                  clear_done,
   output logic                  err_index
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned NW = $clog2(NUM_POS);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [4:0]            fifo_idx_q  [FIFO_DEPTH];
   logic [4:0]            fifo_idx_d  [FIFO_DEPTH];
   logic [WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
   logic [WIDTH-1:0]      fifo_data_d [FIFO_DEPTH];
   logic                  pending_q, pending_d;
   logic [WIDTH-1:0]      clr_val_q, clr_val_d;
   logic [NW-1:0]         fill_q, fill_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic accept, in_range, push, pop;

   assign req_ready = (count_q < CW'(FIFO_DEPTH)) && !pending_q && (state_q != CLEAR);
   assign accept    = req_valid && req_ready;
   assign in_range  = 32'(req_index) < NUM_POS;
   assign push      = accept && in_range;
   assign pop       = (state_q == IDLE) && (count_q != '0);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q + CW'(push) - CW'(pop);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_idx_d  = fifo_idx_q;
      fifo_data_d = fifo_data_q;
      pending_d   = pending_q;
      clr_val_d   = clr_val_q;
      fill_d      = fill_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      done_d      = 1'b0;
      err_d       = accept && !in_range;

      if (push) begin
         fifo_idx_d[wr_ptr_q]  = req_index;
         fifo_data_d[wr_ptr_q] = req_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               rd_ptr_d    = rd_ptr_q + 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(fifo_idx_q[rd_ptr_q]);
               mem_wdata_d = fifo_data_q[rd_ptr_q];
            end else if (pending_q) begin
               state_d   = CLEAR;
               fill_d    = '0;
               pending_d = 1'b0;
            end
         end
         CLEAR: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(fill_q);
            mem_wdata_d = clr_val_q;
            if (fill_q == NW'(NUM_POS - 1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               fill_d = fill_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A pending or running clear already owns the latched value; later starts are dropped.
      if (clear_start && !pending_q && (state_q != CLEAR)) begin
         pending_d = 1'b1;
         clr_val_d = clear_value;
      end
   end

   always_ff @(posedge clk50MHz) begin
      fifo_idx_q  <= fifo_idx_d;
      fifo_data_q <= fifo_data_d;
      if (clr) begin
         state_q     <= IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pending_q   <= 1'b0;
         clr_val_q   <= '0;
         fill_q      <= '0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pending_q   <= pending_d;
         clr_val_q   <= clr_val_d;
         fill_q      <= fill_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign clear_done = done_q;
   assign err_index  = err_q;
   assign busy       = (count_q != '0) || pending_q || (state_q == CLEAR) || mem_we_q;

endmodule

// File: doc/board_mem_writer.md
Name: board_mem_writer

Overview:
- Write-side counterpart of the VGA board readout. Game/CPU logic posts board-position updates (index 0..NUM_POS-1 plus a data word) through a valid/ready handshake.
- Updates are buffered in a small FIFO and written one per cycle into the display region of BRAM, at BASE_ADDR+index, through a dedicated write port. The VGA controller scans that region on the other port.
- A bulk clear command fills the whole region with one value.

Parameters:
- WIDTH, 16, data word width of each board position
- ADDR_WIDTH, 10, BRAM address width
- BASE_ADDR, 10'h100, first address of the board region
- NUM_POS, 30, number of board positions (region is BASE_ADDR .. BASE_ADDR+NUM_POS-1)
- FIFO_DEPTH, 4, update queue depth (power of two)

Ports:
- clk50MHz  in  1  system clock, all logic on rising edge
- clr  in  1  synchronous active-high reset
- req_valid  in  1  update request valid
- req_ready  out  1  block can accept an update this cycle
- req_index  in  5  board position index
- req_data  in  WIDTH  value to store
- clear_start  in  1  single-cycle pulse requesting a region fill
- clear_value  in  WIDTH  fill value, sampled with clear_start
- mem_addr  out  ADDR_WIDTH  BRAM write address, registered
- mem_wdata  out  WIDTH  BRAM write data, registered
- mem_we  out  1  BRAM write enable, registered
- busy  out  1  work pending or in progress
- clear_done  out  1  one-cycle pulse when the last fill write is issued
- err_index  out  1  one-cycle pulse when an out-of-range request is dropped

Behaviour:
- Reset (clr=1 at an edge):
  - FIFO emptied; state IDLE; clear_pending=0; fill counter=0.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, clear_done=0, err_index=0.
  - Applies mid-clear or mid-drain; BRAM contents already written are not undone.
- Handshake:
  - Transfer occurs at an edge where req_valid && req_ready.
  - req_ready = (count < FIFO_DEPTH) && !clear_pending && state!=CLEAR. Combinational from registers; no full-FIFO pass-through.
- Index check:
  - An accepted request with req_index >= NUM_POS is not enqueued.
  - err_index pulses high in the following cycle.
- States IDLE, CLEAR:
  - IDLE, FIFO non-empty: pop head each edge. Registered outputs take mem_we=1, mem_addr=BASE_ADDR+index (ADDR_WIDTH-bit add), mem_wdata=data.
  - Throughput is one write per cycle.
  - Latency: request accepted at edge N into an empty FIFO → popped at edge N+1 → mem_we high for the cycle after edge N+1.
  - IDLE, FIFO empty, clear_pending=1: go to CLEAR, fill counter=0, clear_pending=0.
  - CLEAR: each edge registers mem_we=1, mem_addr=BASE_ADDR+counter, mem_wdata=latched clear_value, then counter+1.
  - CLEAR exit: at the edge issuing counter=NUM_POS-1, clear_done pulses with that write and state returns to IDLE. The fill totals exactly NUM_POS writes.
  - Any edge with no write issued: mem_we=0; mem_addr/mem_wdata hold.
- Clear ordering:
  - clear_start sets clear_pending and latches clear_value.
  - Requests already queued drain first. New requests are blocked (req_ready=0) until the fill completes, so no update is lost or reordered against the clear.
  - clear_start while clear_pending or in CLEAR: ignored, latched value unchanged.
  - clear_start coincident with a request transfer: the request is accepted (ready was high) and drains before the fill.
- Simultaneous enqueue and pop: count unchanged, both take effect.
- busy = (count!=0) || clear_pending || state==CLEAR || mem_we.
- Memory port write-only: no read, no arbitration. Port collision with the VGA reader is resolved by the BRAM.

Test Plan:
- Reset then single request idx=3, data=16'h0042 → mem_we high exactly one cycle, two edges after acceptance, mem_addr=10'h103, mem_wdata=16'h0042; busy returns 0.
- Back-to-back requests idx 0,1,2,3,4 with req_valid held → req_ready drops only when count=4. Writes issue on consecutive cycles to 10'h100..10'h104 in order, with no duplicates.
- Request idx=30, data=16'hFFFF → err_index one-cycle pulse, no mem_we, FIFO count stays 0; idx=29 → write to 10'h11D.
- Queue idx=5 and idx=6, then clear_start with clear_value=16'h0007 → idx 5/6 written first. Exactly 30 fill writes follow at 10'h100..10'h11D with data 16'h0007; clear_done coincides with the 10'h11D write; req_ready stays 0 from clear_start until after clear_done.
- Second clear_start during fill with clear_value=16'h1111 → ignored; all 30 fill writes keep 16'h0007, single clear_done.
- clr asserted at the 10th fill write → next cycle mem_we=0, busy=0, req_ready=1, no clear_done; a new request is then written normally.
